// File: rtl/serial_receiver_pkg.sv
// Shared frame constants and state encodings for the serial link
// (serial_receiver and serial_transmitter).
package serial_receiver_pkg;

    localparam int unsigned SYNC_LEN    = 3;
    localparam int unsigned PAYLOAD_LEN = 18;
    localparam int unsigned WORD_BITS   = 17;
    localparam int unsigned WORDS       = 6;
    localparam int unsigned FRAME_BITS  = WORDS * WORD_BITS;

    typedef enum logic [1:0] {
        HUNT,
        COLLECT,
        CHECK
    } frame_state_e;

    typedef enum logic [2:0] {
        U_WAIT_HIGH,
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    // Upper bits of a 24-bit payload word must be zero for the frame to be valid.
    function automatic logic guard_ok(input logic [23-WORD_BITS:0] guard);
        return guard == '0;
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Serial line plus decoded-frame outputs of the receiver.
interface serial_receiver_if;
    import serial_receiver_pkg::*;

    logic                  rx;
    logic [FRAME_BITS-1:0] sensor_iterations;
    logic                  data_availible;
    logic                  frame_error;

    modport master (
        output rx,
        input  sensor_iterations,
        input  data_availible,
        input  frame_error
    );

    modport slave (
        input  rx,
        output sensor_iterations,
        output data_availible,
        output frame_error
    );

endinterface

// File: rtl/serial_receiver_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, LSB first.
module uart_rx
    import serial_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       stop_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    uart_state_e   state_q, state_d;
    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          stop_err_q, stop_err_d;

    always_comb begin
        meta_d     = rx;
        sync_d     = meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        stop_err_d = 1'b0;
        unique case (state_q)
            U_WAIT_HIGH: begin
                if (sync_q) state_d = U_IDLE;
            end
            U_IDLE: begin
                if (!sync_q) begin
                    state_d = U_START;
                    cnt_d   = '0;
                end
            end
            U_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_d = sync_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            U_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = U_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            U_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        state_d = U_IDLE;
                    end else begin
                        stop_err_d = 1'b1;
                        state_d    = U_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = U_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= U_WAIT_HIGH;
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign data     = shift_q;
    assign valid    = valid_q;
    assign stop_err = stop_err_q;

endmodule

// File: rtl/serial_receiver.sv
// Frame receiver: hunts for 3 zero sync bytes, collects 18 payload bytes and
// publishes six 17-bit words when all guard bits are clear.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned IDLE_TIMEOUT = 2083
) (
    input logic              clk_12MHz,
    input logic              rst,
    serial_receiver_if.slave bus
);

    localparam int unsigned SW = $clog2(SYNC_LEN);
    localparam int unsigned XW = $clog2(PAYLOAD_LEN);
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT);
    localparam int unsigned BW = PAYLOAD_LEN * 8;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_stop_err;

    uart_rx #(
        .CLKS_PER_BIT(CLK_HZ / BAUD)
    ) u_uart_rx (
        .clk      (clk_12MHz),
        .rst      (rst),
        .rx       (bus.rx),
        .data     (rx_data),
        .valid    (rx_valid),
        .stop_err (rx_stop_err)
    );

    frame_state_e          state_q, state_d;
    logic [SW-1:0]         sync_cnt_q, sync_cnt_d;
    logic [XW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [BW-1:0]         buf_q, buf_d;
    logic [FRAME_BITS-1:0] sensor_q, sensor_d;
    logic                  data_av_q, data_av_d;
    logic                  frame_err_q, frame_err_d;

    logic                  expired;
    logic                  words_ok;
    logic [FRAME_BITS-1:0] frame_words;
    logic [23:0]           word;

    always_comb begin
        expired = (idle_q == IW'(IDLE_TIMEOUT - 1));
        idle_d  = (rx_valid || expired) ? '0 : idle_q + 1'b1;
    end

    // Payload bytes shift in from the bottom, so byte 0 ends up in the top byte.
    always_comb begin
        words_ok    = 1'b1;
        frame_words = '0;
        word        = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            word = buf_q[(PAYLOAD_LEN - 3 - 3 * w) * 8 +: 24];
            if (!guard_ok(word[23:WORD_BITS])) words_ok = 1'b0;
            frame_words[(WORDS - 1 - w) * WORD_BITS +: WORD_BITS] = word[WORD_BITS-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        sensor_d    = sensor_q;
        data_av_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (rx_valid) begin
                    if (rx_data != 8'h00) begin
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q == SW'(SYNC_LEN - 1)) begin
                        sync_cnt_d = '0;
                        idx_d      = '0;
                        state_d    = COLLECT;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end else if (rx_stop_err || expired) begin
                    sync_cnt_d = '0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    buf_d = {buf_q[BW-9:0], rx_data};
                    if (idx_q == XW'(PAYLOAD_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (rx_stop_err || expired) begin
                    frame_err_d = 1'b1;
                    idx_d       = '0;
                    state_d     = HUNT;
                end
            end
            CHECK: begin
                if (words_ok) begin
                    sensor_d  = frame_words;
                    data_av_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk_12MHz) begin
        if (rst) begin
            state_q     <= HUNT;
            sync_cnt_q  <= '0;
            idx_q       <= '0;
            idle_q      <= '0;
            sensor_q    <= '0;
            data_av_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            buf_q       <= buf_d;
            sensor_q    <= sensor_d;
            data_av_q   <= data_av_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.sensor_iterations = sensor_q;
    assign bus.data_availible    = data_av_q;
    assign bus.frame_error       = frame_err_q;

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate (8N1).
REQ-003 Parameter IDLE_TIMEOUT, default 2083, clock cycles of line inactivity (no byte strobe) that abort a frame or clear a partial sync count.
REQ-004 clk_12MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx  in  1  asynchronous serial line, idle high.
REQ-007 sensor_iterations  out  102  last good frame: six 17-bit words, word0 at [101:85] down to word5 at [16:0].
REQ-008 data_availible  out  1  one-cycle pulse; sensor_iterations updated in the same cycle.
REQ-009 frame_error  out  1  one-cycle pulse on a discarded frame.

Function
REQ-010 Frame format: 3 sync bytes of 0x00, then 18 payload bytes; payload word w (0..5) is bytes 3w..3w+2, sent MSB first, forming 24 bits {b0,b1,b2}.
REQ-011 Each 24-bit word shall carry the 17-bit value in bits [16:0]; bits [23:17] (b0[7:1]) shall be zero, otherwise the frame is invalid.
REQ-012 States: HUNT, COLLECT, CHECK.
REQ-013 HUNT: a 0x00 byte increments the sync count; a nonzero byte clears it; an IDLE_TIMEOUT expiry clears it; the third consecutive 0x00 clears it and enters COLLECT with byte index 0.
REQ-014 COLLECT: each byte strobe stores the byte at the current index and increments the index; storing index 17 enters CHECK on the next cycle.
REQ-015 COLLECT: no further sync search; 0x00 payload bytes are data.
REQ-016 COLLECT: IDLE_TIMEOUT expiry, or a UART stop-bit error, pulses frame_error, discards the partial frame and returns to HUNT.
REQ-017 CHECK (one cycle): if every word satisfies REQ-011, load sensor_iterations and pulse data_availible; otherwise pulse frame_error and leave sensor_iterations unchanged; both cases return to HUNT.
REQ-018 Latency: data_availible asserts exactly 2 cycles after the byte strobe of payload byte 17.
REQ-019 A UART stop-bit error in HUNT shall clear the sync count without pulsing frame_error.
REQ-020 The idle counter restarts on every byte strobe; a strobe in the same cycle as expiry takes priority, and the byte is processed.
REQ-021 data_availible and frame_error shall never assert in the same cycle.
REQ-022 sensor_iterations shall hold its value between good frames.

Reset
REQ-023 rst shall force HUNT, sync count 0, byte index 0, idle counter 0, and sensor_iterations, data_availible and frame_error to 0.
REQ-024 Assertion of rst mid-frame shall discard the frame with no frame_error pulse.
REQ-025 The UART sub-module shall reset to idle and wait for a high line before it detects a start bit.

Structure
REQ-026 A shared package shall hold the FSM state encodings, SYNC_LEN=3, PAYLOAD_LEN=18, WORD_BITS=17 and WORDS=6, also consumed by serial_transmitter.
REQ-027 One sub-module, uart_rx: 2-FF synchroniser, start-bit mid-bit sampling, 8N1 LSB-first; outputs data[7:0], a valid pulse and a stop_err pulse.
REQ-028 Frame logic (FSM, counters, 18-byte buffer, check) shall reside in serial_receiver.

Verification
REQ-029 Good frame: 00 00 00, then words 0x00001..0x00006 (e.g. 00 00 01 ... 00 00 06) -> one data_availible; sensor_iterations = {17'd1,...,17'd6}; no frame_error.
REQ-030 Max values: all words 0x1FFFF (01 FF FF) -> sensor_iterations = all ones; back-to-back second frame with zeros -> all zeros.
REQ-031 Bad guard bits: word2 b0 = 0x03 -> frame_error pulse; sensor_iterations keeps its previous value.
REQ-032 Truncation: send sync plus 10 payload bytes, then idle > IDLE_TIMEOUT -> frame_error; the following good frame is accepted.
REQ-033 Resync: 00 00 55, then a good frame -> exactly one data_availible, with the correct words.
REQ-034 Reset mid-frame: assert rst after payload byte 7 -> outputs 0, no pulses; the next full frame is accepted.
